fpu_arbiter: RTL

Shares one FPU core among `N_REQ` requesters. It arbitrates round-robin, latches the winner's operands and opcode, and drives the FPU's four-beat serial load protocol on `data`/`start`. It then waits for `ready` and returns a one-cycle `done` plus error status to the granted requester. It sits between client logic and the `FPU` instance; the FPU's `data`/`start`/`ready`/`error` pins connect only to this block.

---
 rtl/fpu_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter that shares one serial-load FPU among N_REQ requesters:
// latches the winner's operands, streams four beats, then waits for ready or the watchdog.
module fpu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [16*N_REQ-1:0] req_a,
  input  logic [16*N_REQ-1:0] req_b,
  input  logic [2*N_REQ-1:0]  req_op,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    done,
  output logic                err,
  output logic                timeout,
  output logic                busy,
  output logic [15:0]         fpu_data,
  output logic                fpu_start,
  input  logic                fpu_ready,
  input  logic                fpu_error
);

  localparam int         IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [9:0] TMO = 10'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [9:0]        wd_q, wd_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     pick_s;
  logic [15:0]       a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic              rdy_q, ferr_q;
  logic [N_REQ-1:0]  grant_q, grant_d, done_q, done_d;
  logic              err_q, err_d, tmo_q, tmo_d, busy_q, busy_d;
  logic [15:0]       data_q, data_d;
  logic              start_q, start_d;

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign timeout   = tmo_q;
  assign busy      = busy_q;
  assign fpu_data  = data_q;
  assign fpu_start = start_q;

  // Round-robin search: scanning downward lets the nearest index after last_q win.
  always_comb begin : rr_search
    pick_s = last_q;
    for (int k = N_REQ; k >= 1; k--) begin
      pick_s = req[IW'((int'(last_q) + k) % N_REQ)] ? IW'((int'(last_q) + k) % N_REQ) : pick_s;
    end
  end

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    wd_d    = wd_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    grant_d = grant_q;
    err_d   = err_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d         = S_SEND;
          step_d          = 3'd0;
          last_d          = pick_s;
          a_d             = req_a[16*int'(pick_s) +: 16];
          b_d             = req_b[16*int'(pick_s) +: 16];
          op_d            = req_op[2*int'(pick_s) +: 2];
          grant_d         = '0;
          grant_d[pick_s] = 1'b1;
        end else begin
          grant_d = '0;
        end
      end
      S_SEND: begin
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = S_WAIT_LO;
          wd_d    = 10'd0;
        end else begin
          state_d = S_SEND;
        end
      end
      S_WAIT_LO: begin
        wd_d = wd_q + 10'd1;
        if (wd_q == TMO) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end else if (!rdy_q) begin
          state_d = S_WAIT_HI;
        end else begin
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_HI: begin
        wd_d = wd_q + 10'd1;
        if (wd_q == TMO) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end else if (rdy_q) begin
          state_d = S_DONE;
          err_d   = ferr_q;
          tmo_d   = 1'b0;
        end else begin
          state_d = S_WAIT_HI;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    done_d = (state_d == S_DONE) ? grant_q : '0;
    busy_d = (state_d != S_IDLE);

    if (state_d == S_SEND) begin
      start_d = ~step_d[0];
      case (step_d)
        3'd0:    data_d = a_d;
        3'd2:    data_d = b_d;
        3'd4:    data_d = {14'd0, op_d};
        default: data_d = 16'h0000;
      endcase
    end else begin
      start_d = 1'b0;
      data_d  = 16'h0000;
    end
  end

  // State, latched transaction and registered outputs; FPU pins are registered on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      wd_q    <= 10'd0;
      last_q  <= IW'(N_REQ - 1);
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      op_q    <= 2'd0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= 16'h0000;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wd_q    <= wd_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rdy_q   <= fpu_ready;
      ferr_q  <= fpu_error;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      start_q <= start_d;
    end
  end

endmodule
